// File: rtl/prores_sb_pkg.sv
// Shared types and constants for the set_bit arbiter slice.
// Both bitstream producers and the arbiter agree on these widths.
package prores_sb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        AUTO_FLUSH,
        RELEASE
    } sb_state_t;

    localparam int SB_VAL_W      = 64;
    localparam int SB_SIZE_W     = 7;
    localparam int SB_MAX_BITS   = 64;
    localparam int REQ_HEADER    = 0;
    localparam int REQ_COMPONENT = 1;

    // Zero bits needed to close the current partial byte.
    function automatic logic [3:0] sb_pad_bits(input logic [2:0] phase);
        return (phase == 3'd0) ? 4'd0 : (4'd8 - {1'b0, phase});
    endfunction

endpackage

// File: rtl/set_bit_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester found searching
// upward from i_ptr (wrapping) wins; result is one-hot plus its index.
module rr_arbiter
    import prores_sb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
            end
        end
    end

endmodule

// File: rtl/set_bit_arbiter.sv
// Shares one set_bit packer between bitstream producers using a
// request/grant session, auto-flushing partial bytes on release.
module set_bit_arbiter
    import prores_sb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  enable,
    input  logic [NUM_REQ-1:0][SB_VAL_W-1:0]    val,
    input  logic [NUM_REQ-1:0][SB_SIZE_W-1:0]   size_of_bit,
    input  logic [NUM_REQ-1:0]                  flush,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                sb_enable,
    output logic [SB_VAL_W-1:0]                 sb_val,
    output logic [63:0]                         sb_size_of_bit,
    output logic                                sb_flush,
    output logic                                session_done,
    output logic [IDX_W-1:0]                    session_owner,
    output logic [CNT_W-1:0]                    session_bits,
    output logic                                protocol_error
);

    sb_state_t            r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [2:0]           r_phase;
    logic                 r_sb_enable;
    logic [SB_VAL_W-1:0]  r_sb_val;
    logic [SB_SIZE_W-1:0] r_sb_size;
    logic                 r_sb_flush;
    logic                 r_done;
    logic [IDX_W-1:0]     r_sess_owner;
    logic [CNT_W-1:0]     r_sess_bits;
    logic                 r_error;

    logic [NUM_REQ-1:0]   w_arb_grant;
    logic [IDX_W-1:0]     w_arb_idx;
    logic [IDX_W-1:0]     w_ptr_next;
    logic                 w_own_req;
    logic                 w_own_en;
    logic                 w_own_fl;
    logic [SB_SIZE_W-1:0] w_own_size;
    logic [SB_VAL_W-1:0]  w_own_val;
    logic                 w_size_ok;
    logic [NUM_REQ-1:0]   w_owner_mask;
    logic                 w_stray;
    logic [SB_SIZE_W-1:0] w_add;
    logic [CNT_W:0]       w_cnt_sum;
    logic [CNT_W-1:0]     w_cnt_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    always_comb begin
        w_own_req    = req[r_owner];
        w_own_en     = enable[r_owner];
        w_own_fl     = flush[r_owner];
        w_own_size   = size_of_bit[r_owner];
        w_own_val    = val[r_owner];
        w_size_ok    = (w_own_size != '0) && (w_own_size <= SB_SIZE_W'(SB_MAX_BITS));
        // Only a BUSY owner may drive beats; anything else is a producer bug.
        w_owner_mask = (r_state == BUSY) ? r_grant : '0;
        w_stray      = |((enable | flush) & ~w_owner_mask);
        w_add        = (w_own_req && !w_own_fl && w_own_en) ? w_own_size
                                                            : SB_SIZE_W'(sb_pad_bits(r_phase));
        w_cnt_sum    = {1'b0, r_bit_cnt} + (CNT_W+1)'(w_add);
        w_cnt_next   = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
        w_ptr_next   = (w_arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (w_arb_idx + IDX_W'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_bit_cnt    <= '0;
            r_phase      <= '0;
            r_sb_enable  <= 1'b0;
            r_sb_val     <= '0;
            r_sb_size    <= '0;
            r_sb_flush   <= 1'b0;
            r_done       <= 1'b0;
            r_sess_owner <= '0;
            r_sess_bits  <= '0;
            r_error      <= 1'b0;
        end else begin
            r_sb_enable  <= 1'b0;
            r_sb_val     <= '0;
            r_sb_size    <= '0;
            r_sb_flush   <= 1'b0;
            r_done       <= 1'b0;
            r_sess_owner <= '0;
            r_sess_bits  <= '0;
            if (w_stray) begin
                r_error <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant   <= w_arb_grant;
                        r_owner   <= w_arb_idx;
                        r_ptr     <= w_ptr_next;
                        r_bit_cnt <= '0;
                        r_phase   <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_own_req) begin
                        if (w_own_en || w_own_fl) begin
                            r_error <= 1'b1;
                        end
                        if (r_phase != 3'd0) begin
                            r_sb_flush <= 1'b1;
                            r_bit_cnt  <= w_cnt_next;
                            r_phase    <= '0;
                            r_state    <= AUTO_FLUSH;
                        end else begin
                            r_grant      <= '0;
                            r_done       <= 1'b1;
                            r_sess_owner <= r_owner;
                            r_sess_bits  <= r_bit_cnt;
                            r_state      <= RELEASE;
                        end
                    end else if (w_own_fl) begin
                        r_sb_flush <= 1'b1;
                        r_bit_cnt  <= w_cnt_next;
                        r_phase    <= '0;
                        if (w_own_en) begin
                            r_error <= 1'b1;
                        end
                    end else if (w_own_en) begin
                        if (w_size_ok) begin
                            r_sb_enable <= 1'b1;
                            r_sb_val    <= w_own_val;
                            r_sb_size   <= w_own_size;
                            r_bit_cnt   <= w_cnt_next;
                            r_phase     <= r_phase + w_own_size[2:0];
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                AUTO_FLUSH: begin
                    r_grant      <= '0;
                    r_done       <= 1'b1;
                    r_sess_owner <= r_owner;
                    r_sess_bits  <= r_bit_cnt;
                    r_state      <= RELEASE;
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant          = r_grant;
    assign sb_enable      = r_sb_enable;
    assign sb_val         = r_sb_val;
    assign sb_size_of_bit = {{(64 - SB_SIZE_W){1'b0}}, r_sb_size};
    assign sb_flush       = r_sb_flush;
    assign session_done   = r_done;
    assign session_owner  = r_sess_owner;
    assign session_bits   = r_sess_bits;
    assign protocol_error = r_error;

endmodule

// File: tb/tb_set_bit_arbiter.sv
// Directed bench for set_bit_arbiter: a session-level reference model is
// compared every cycle, plus literal expectations per scenario.
module tb_set_bit_arbiter;

    logic             clock;
    logic             reset_n;
    logic [1:0]       req;
    logic [1:0]       enable;
    logic [1:0][63:0] val;
    logic [1:0][6:0]  size_of_bit;
    logic [1:0]       flush;
    logic [1:0]       grant;
    logic             sb_enable;
    logic [63:0]      sb_val;
    logic [63:0]      sb_size_of_bit;
    logic             sb_flush;
    logic             session_done;
    logic [0:0]       session_owner;
    logic [31:0]      session_bits;
    logic             protocol_error;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    // Expected outputs produced by the model.
    logic [1:0]  eGrant = '0;
    logic        eSbEn = 0, eSbFlush = 0, eDone = 0, eErr = 0, eRst = 0;
    logic [63:0] eSbVal = '0, eSbSize = '0;
    logic        eOwner = 0;
    logic [31:0] eBits = '0;

    localparam int M_IDLE = 0, M_SESS = 1, M_AUTOF = 2, M_REL = 3;
    int     mStage = M_IDLE;
    int     mNext  = 0;
    int     mOwner = 0;
    longint mBits  = 0;

    // Observations of the DUT used by the literal expectations.
    int          recBeats = 0, recFlushes = 0, recDones = 0;
    int          recDoneCyc = 0, recFlushCyc = 0, recRiseCyc = 0;
    logic [31:0] recBits = '0;
    logic        recOwner = 0;
    logic [1:0]  prevGrant = '0;

    set_bit_arbiter #(.NUM_REQ(2), .CNT_W(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req            (req),
        .enable         (enable),
        .val            (val),
        .size_of_bit    (size_of_bit),
        .flush          (flush),
        .grant          (grant),
        .sb_enable      (sb_enable),
        .sb_val         (sb_val),
        .sb_size_of_bit (sb_size_of_bit),
        .sb_flush       (sb_flush),
        .session_done   (session_done),
        .session_owner  (session_owner),
        .session_bits   (session_bits),
        .protocol_error (protocol_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // Session-level reference: bits are a plain running total, byte phase
    // is derived from it, and round-up is done arithmetically.
    always @(posedge clock) begin
        logic own;
        int   pick;
        int   c;
        eSbEn = 0; eSbVal = '0; eSbSize = '0; eSbFlush = 0;
        eDone = 0; eOwner = 0; eBits = '0; eRst = 0;
        if (!reset_n) begin
            eGrant = '0; eErr = 0; eRst = 1;
            mStage = M_IDLE; mNext = 0; mOwner = 0; mBits = 0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if ((enable[r[0]] || flush[r[0]]) && !(mStage == M_SESS && r == mOwner)) eErr = 1;
            end
            own = mOwner[0];
            case (mStage)
                M_IDLE: begin
                    pick = -1;
                    for (int k = 0; k < 2; k++) begin
                        c = (mNext + k) % 2;
                        if (pick < 0 && req[c[0]]) pick = c;
                    end
                    if (pick >= 0) begin
                        mOwner = pick;
                        mNext  = (pick + 1) % 2;
                        mBits  = 0;
                        eGrant = 2'b01 << pick;
                        mStage = M_SESS;
                    end
                end
                M_SESS: begin
                    if (!req[own]) begin
                        if (enable[own] || flush[own]) eErr = 1;
                        if (mBits % 8 != 0) begin
                            mBits    = (mBits + 7) / 8 * 8;
                            eSbFlush = 1;
                            mStage   = M_AUTOF;
                        end else begin
                            eGrant = '0; eDone = 1; eOwner = own;
                            eBits  = (mBits > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : mBits[31:0];
                            mStage = M_REL;
                        end
                    end else if (flush[own]) begin
                        eSbFlush = 1;
                        mBits    = (mBits + 7) / 8 * 8;
                        if (enable[own]) eErr = 1;
                    end else if (enable[own]) begin
                        if (size_of_bit[own] >= 1 && size_of_bit[own] <= 64) begin
                            eSbEn   = 1;
                            eSbVal  = val[own];
                            eSbSize = 64'(size_of_bit[own]);
                            mBits   = mBits + longint'(size_of_bit[own]);
                        end else begin
                            eErr = 1;
                        end
                    end
                end
                M_AUTOF: begin
                    eGrant = '0; eDone = 1; eOwner = own;
                    eBits  = (mBits > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : mBits[31:0];
                    mStage = M_REL;
                end
                default: mStage = M_IDLE;
            endcase
        end
    end

    // Single compare process, sampling 3 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #3;
            cyc++;
            checkOutput("grant", 64'(grant), 64'(eGrant));
            checkOutput("sb_enable", 64'(sb_enable), 64'(eSbEn));
            checkOutput("sb_val", sb_val, eSbVal);
            checkOutput("sb_size_of_bit", sb_size_of_bit, eSbSize);
            checkOutput("sb_flush", 64'(sb_flush), 64'(eSbFlush));
            checkOutput("session_done", 64'(session_done), 64'(eDone));
            checkOutput("protocol_error", 64'(protocol_error), 64'(eErr));
            if (eDone || eRst) begin
                checkOutput("session_owner", 64'(session_owner), 64'(eOwner));
                checkOutput("session_bits", 64'(session_bits), 64'(eBits));
            end
            if (sb_enable) recBeats++;
            if (sb_flush) begin recFlushes++; recFlushCyc = cyc; end
            if (session_done) begin
                recDones++; recDoneCyc = cyc; recBits = session_bits; recOwner = session_owner[0];
            end
            if (grant == 2'b10 && prevGrant != 2'b10) recRiseCyc = cyc;
            prevGrant = grant;
        end
    end

    task automatic clearRecord();
        recBeats = 0; recFlushes = 0; recDones = 0;
        recDoneCyc = 0; recFlushCyc = 0; recRiseCyc = 0;
        recBits = '0; recOwner = 0;
    endtask

    // Drives one cycle of inputs (from a falling edge) and waits for the next falling edge.
    task automatic applyStimulus(input logic [1:0] rq, input logic who, input logic en,
                                 input logic fl, input logic [6:0] sz, input logic [63:0] v);
        req = rq; enable = '0; flush = '0; size_of_bit = '0; val = '0;
        enable[who] = en; flush[who] = fl; size_of_bit[who] = sz; val[who] = v;
        @(negedge clock);
    endtask

    task automatic beat(input logic [1:0] rq, input logic who, input logic [6:0] sz, input logic [63:0] v);
        applyStimulus(rq, who, 1'b1, 1'b0, sz, v);
    endtask

    task automatic hold(input logic [1:0] rq, input int n);
        repeat (n) applyStimulus(rq, 1'b0, 1'b0, 1'b0, 7'd0, 64'd0);
    endtask

    task automatic doReset();
        req = '0; enable = '0; flush = '0; size_of_bit = '0; val = '0;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_sb_enable", 64'(sb_enable), 64'd0);
        checkOutput("rst_sb_flush", 64'(sb_flush), 64'd0);
        checkOutput("rst_protocol_error", 64'(protocol_error), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        req = '0; enable = '0; flush = '0; size_of_bit = '0; val = '0;
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        hold(2'b00, 1);

        $display("[TB] single session, owner 0, beats 3/5/16");
        clearRecord();
        hold(2'b01, 1);
        checkOutput("s1_grant", 64'(grant), 64'd1);
        beat(2'b01, 1'b0, 7'd3, 64'h5);
        beat(2'b01, 1'b0, 7'd5, 64'h1A);
        beat(2'b01, 1'b0, 7'd16, 64'hBEEF);
        hold(2'b00, 3);
        checkOutput("s1_beats", 64'(recBeats), 64'd3);
        checkOutput("s1_flushes", 64'(recFlushes), 64'd0);
        checkOutput("s1_bits", 64'(recBits), 64'd24);
        checkOutput("s1_owner", 64'(recOwner), 64'd0);

        $display("[TB] auto-flush, owner 1, beats 7/2");
        clearRecord();
        hold(2'b10, 1);
        beat(2'b10, 1'b1, 7'd7, 64'h7F);
        beat(2'b10, 1'b1, 7'd2, 64'h2);
        hold(2'b00, 4);
        checkOutput("s2_flushes", 64'(recFlushes), 64'd1);
        checkOutput("s2_flush_to_done", 64'(recDoneCyc - recFlushCyc), 64'd1);
        checkOutput("s2_bits", 64'(recBits), 64'd16);
        checkOutput("s2_owner", 64'(recOwner), 64'd1);

        $display("[TB] contention after reset");
        doReset();
        clearRecord();
        hold(2'b11, 1);
        checkOutput("s3_first_grant", 64'(grant), 64'd1);
        beat(2'b11, 1'b0, 7'd8, 64'hA5);
        hold(2'b10, 4);
        checkOutput("s3_handover_gap", 64'(recRiseCyc - recDoneCyc), 64'd2);
        checkOutput("s3_bits0", 64'(recBits), 64'd8);
        checkOutput("s3_second_grant", 64'(grant), 64'd2);
        hold(2'b00, 3);
        checkOutput("s3_dones", 64'(recDones), 64'd2);
        checkOutput("s3_owner1", 64'(recOwner), 64'd1);
        checkOutput("s3_bits1", 64'(recBits), 64'd0);

        $display("[TB] explicit flush then release");
        clearRecord();
        hold(2'b01, 1);
        beat(2'b01, 1'b0, 7'd3, 64'h6);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 7'd0, 64'd0);
        hold(2'b00, 3);
        checkOutput("s4_flushes", 64'(recFlushes), 64'd1);
        checkOutput("s4_bits", 64'(recBits), 64'd8);
        checkOutput("s4_error", 64'(protocol_error), 64'd0);

        $display("[TB] 64-bit beat boundary");
        clearRecord();
        hold(2'b01, 1);
        beat(2'b01, 1'b0, 7'd64, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(2'b01, 1'b0, 7'd1, 64'h1);
        hold(2'b00, 4);
        checkOutput("s5_beats", 64'(recBeats), 64'd2);
        checkOutput("s5_flushes", 64'(recFlushes), 64'd1);
        checkOutput("s5_bits", 64'(recBits), 64'd72);

        $display("[TB] error: non-owner enable");
        doReset();
        clearRecord();
        hold(2'b10, 1);
        beat(2'b10, 1'b0, 7'd8, 64'h33);
        hold(2'b10, 1);
        checkOutput("e1_error", 64'(protocol_error), 64'd1);
        checkOutput("e1_beats", 64'(recBeats), 64'd0);
        hold(2'b00, 3);
        checkOutput("e1_sticky", 64'(protocol_error), 64'd1);

        $display("[TB] error: owner size 65 and 0");
        doReset();
        clearRecord();
        hold(2'b10, 1);
        beat(2'b10, 1'b1, 7'd65, 64'h44);
        beat(2'b10, 1'b1, 7'd0, 64'h45);
        hold(2'b10, 1);
        checkOutput("e2_error", 64'(protocol_error), 64'd1);
        checkOutput("e2_beats", 64'(recBeats), 64'd0);
        hold(2'b00, 3);

        $display("[TB] error: owner enable with flush");
        doReset();
        clearRecord();
        hold(2'b10, 1);
        beat(2'b10, 1'b1, 7'd3, 64'h7);
        applyStimulus(2'b10, 1'b1, 1'b1, 1'b1, 7'd8, 64'hFF);
        hold(2'b00, 3);
        checkOutput("e3_error", 64'(protocol_error), 64'd1);
        checkOutput("e3_beats", 64'(recBeats), 64'd1);
        checkOutput("e3_flushes", 64'(recFlushes), 64'd1);
        checkOutput("e3_bits", 64'(recBits), 64'd8);

        $display("[TB] reset mid-session");
        doReset();
        hold(2'b01, 1);
        beat(2'b01, 1'b0, 7'd5, 64'h1F);
        clearRecord();
        doReset();
        hold(2'b10, 1);
        checkOutput("r_grant", 64'(grant), 64'd2);
        beat(2'b10, 1'b1, 7'd8, 64'h99);
        hold(2'b00, 3);
        checkOutput("r_flushes", 64'(recFlushes), 64'd0);
        checkOutput("r_bits", 64'(recBits), 64'd8);
        checkOutput("r_owner", 64'(recOwner), 64'd1);
        checkOutput("r_dones", 64'(recDones), 64'd1);

        hold(2'b00, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/set_bit_arbiter.md
# set_bit_arbiter

Sequences and shares the single `set_bit` bit-packer between multiple bitstream producers (requester 0 = `header`, requester 1 = `component`). It replaces the OR-combining of producer buses with an explicit request/grant session protocol. It forwards only the owner's beats, auto-flushes a partial byte when the owner releases, and reports each session's bit count to the slice `sequencer`.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters; index 0 has first priority after reset.
- CNT_W, 32, width of session bit counter.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester session request; level, held for whole session.
- enable  in  NUM_REQ  per-requester beat valid.
- val  in  NUM_REQ x 64  beat data, right-aligned.
- size_of_bit  in  NUM_REQ x 7  beat length in bits, legal 1..64.
- flush  in  NUM_REQ  pad current byte with zeros.
- grant  out  NUM_REQ  one-hot session ownership.
- sb_enable  out  1  to `set_bit.enable`.
- sb_val  out  64  to `set_bit.val`.
- sb_size_of_bit  out  64  to `set_bit.size_of_bit`, zero-extended.
- sb_flush  out  1  to `set_bit.flush_bit`.
- session_done  out  1  one-cycle pulse at end of session.
- session_owner  out  $clog2(NUM_REQ)  index of finished owner, valid with session_done.
- session_bits  out  CNT_W  bits emitted in finished session including padding, valid with session_done.
- protocol_error  out  1  sticky error flag, cleared only by reset.

## Operation
- States: IDLE, BUSY, AUTO_FLUSH, RELEASE.
- IDLE: if any `req` is high, pick a winner round-robin, starting at the index after the last owner (index 0 after reset). Register `grant` one-hot, clear bit_cnt and phase, go to BUSY.
- BUSY, owner `enable=1` with `flush=0`, size 1..64:
  - Forward the beat.
  - bit_cnt += size.
  - phase = (phase + size) mod 8.
- BUSY, owner `flush=1`:
  - Forward `sb_flush=1` with `sb_enable=0`.
  - If phase≠0, bit_cnt += 8−phase.
  - phase = 0.
  - If `enable` was also high: drop the beat and set protocol_error.
- BUSY, owner `enable=1` with size 0 or >64: drop the beat, set protocol_error.
- BUSY, owner `req` sampled low:
  - Any `enable` or `flush` in that cycle is dropped and sets protocol_error.
  - Go to AUTO_FLUSH if phase≠0, else RELEASE.
- AUTO_FLUSH: drive `sb_flush=1` for one cycle, round bit_cnt up to a byte multiple, go to RELEASE.
- RELEASE:
  - `grant` = 0.
  - Pulse `session_done`, with `session_owner` and `session_bits` set to the final bit_cnt.
  - Go to IDLE.
- Non-owner `enable` or `flush` is ignored and sets protocol_error. Non-owner `req` just waits.
- bit_cnt saturates at 2^CNT_W−1; it does not wrap.
- Reset, including mid-session:
  - All outputs 0: grant, sb_*, session_*, protocol_error.
  - State returns to IDLE, RR pointer to 0.
  - No flush is issued for an abandoned partial byte.

## Timing
- All outputs are registered.
- Grant latency: first `req` sampled high in cycle t gives `grant` high in t+1. The requester's first beat is accepted when `grant` is high at the sampling edge, i.e. cycle t+1 at the earliest.
- Beat latency: beat accepted in cycle t appears on `sb_*` in t+1, one beat per cycle, no backpressure.
- `sb_*` outputs are all zero in every cycle without a forwarded beat or flush.
- Release with phase≠0: owner `req` low sampled in t → AUTO_FLUSH flush on `sb_flush` in t+1 → `session_done` in t+2.
- Release with phase=0: `session_done` in t+1.
- Handover: `grant` drops in the RELEASE cycle. The next owner's `grant` rises no earlier than 2 cycles after that.
- Simultaneous requests in IDLE resolve in a single cycle, with no bubble beyond the grant latency.

## Structure
- Package `prores_sb_pkg`:
  - `sb_state_t` enum {IDLE, BUSY, AUTO_FLUSH, RELEASE}.
  - SB_VAL_W=64, SB_SIZE_W=7, SB_MAX_BITS=64.
  - REQ_HEADER=0, REQ_COMPONENT=1.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and last-owner pointer, producing a one-hot result plus index.
- Top level holds the FSM, bit_cnt/phase counters, output registers and error flag.

## Test plan
- Single session: req[0]; beats of 3, 5 and 16 bits; req low → three forwarded beats, no auto-flush, session_done with owner 0 and bits=24.
- Auto-flush: req[1]; beats of 7 and 2 bits; req low → one `sb_flush` pulse in the next cycle, then session_done with bits=16.
- Contention: req[0] and req[1] rise together after reset → grant=01 first. After its release, grant=10 two cycles after the RELEASE cycle, not earlier.
- Explicit flush then release: beat of 3 bits, flush, req low → no auto-flush, session_done bits=8.
- Errors: non-owner enable; owner size 65; owner enable with flush → each beat is absent from `sb_*` and protocol_error stays 1 until reset.
- Reset mid-session after a 5-bit beat → all outputs 0 next edge. No flush is issued, and a new req[1] is granted with bit_cnt restarting at 0.
